bsg_skid_buffer: RTL and testbench

BSG_SKID_BUFFER -- requirements
Module: bsg_skid_buffer

---
 rtl/bsg_skid_buffer_if.sv | 33 +++
 rtl/bsg_skid_buffer.sv | 109 ++++++++++
 tb/tb_bsg_skid_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bsg_skid_buffer_if.sv
//============================================================================
// Module  : bsg_skid_buffer_if
// Brief   : Valid/ready/yumi handshake bundle for the two-entry skid buffer.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

interface bsg_skid_buffer_if #(
  parameter int width_p = 64
) ();

  logic [width_p-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               yumi_i;
  logic [1:0]         count_o;

  // master drives the producer/consumer side, slave is the buffer itself
  modport master (
    output data_i, v_i, yumi_i,
    input  ready_o, data_o, v_o, count_o
  );

  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_o, data_o, v_o, count_o
  );

endinterface

`default_nettype wire

// File: rtl/bsg_skid_buffer.sv
//============================================================================
// Module  : bsg_skid_buffer
// Brief   : Two-entry (main + skid) FIFO with fully registered outputs.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module bsg_skid_buffer #(
  parameter int width_p  = 64,
  parameter int harden_p = 0
) (
  input  wire logic           clk_i,
  input  wire logic           reset_n_i,
  bsg_skid_buffer_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             r_state;
  logic [width_p-1:0] r_main;
  logic [width_p-1:0] r_skid;
  logic               r_ready;
  logic               r_v;
  logic [1:0]         r_count;

  logic               w_enq;
  logic               w_deq;

  assign w_enq = bus.v_i    & r_ready;
  assign w_deq = bus.yumi_i & r_v;

  // harden_p is accepted for compatibility only
  if (harden_p != 0) begin : g_hardened
  end else begin : g_soft
  end

  // ready stays low through reset and rises on the first edge after release
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b0;
      r_v     <= 1'b0;
      r_count <= 2'd0;
    end else begin
      r_ready <= 1'b1;
      case (r_state)
        EMPTY: begin
          if (w_enq) begin
            r_state <= ONE;
            r_main  <= bus.data_i;
            r_v     <= 1'b1;
            r_count <= 2'd1;
          end
        end
        ONE: begin
          case ({w_enq, w_deq})
            2'b11: r_main <= bus.data_i;
            2'b10: begin
              r_state <= TWO;
              r_skid  <= bus.data_i;
              r_count <= 2'd2;
              r_ready <= 1'b0;
            end
            2'b01: begin
              r_state <= EMPTY;
              r_v     <= 1'b0;
              r_count <= 2'd0;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (w_deq) begin
            r_state <= ONE;
            r_main  <= r_skid;
            r_count <= 2'd1;
          end else begin
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_v     <= 1'b0;
          r_count <= 2'd0;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.data_o  = r_main;
  assign bus.v_o     = r_v;
  assign bus.count_o = r_count;

`ifndef SYNTHESIS
  a_no_yumi_without_valid : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(bus.yumi_i && !r_v)
  ) else $error("yumi_i asserted while v_o is low");
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_skid_buffer.sv
//============================================================================
// Module  : tb_bsg_skid_buffer
// Brief   : Directed vectors, corner sequences and a scoreboard run.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_bsg_skid_buffer;

  localparam int c_width = 64;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  bsg_skid_buffer_if #(.width_p(c_width)) bus ();

  bsg_skid_buffer #(
    .width_p  (c_width),
    .harden_p (0)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic        y;
    logic [63:0] d;
    logic        ev;
    logic        er;
    logic [1:0]  ec;
    logic        cd;
    logic [63:0] ed;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb[$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic y, input logic [63:0] d);
    bus.v_i    = v;
    bus.yumi_i = y;
    bus.data_i = d;
  endtask

  function automatic vec_t mk(input logic v, input logic y, input logic [63:0] d,
                              input logic ev, input logic er, input logic [1:0] ec,
                              input logic cd, input logic [63:0] ed);
    vec_t t;
    t = '{v, y, d, ev, er, ec, cd, ed};
    return t;
  endfunction

  initial begin
    // inputs, then expected v_o/ready_o/count_o/data_o after the edge
    vecs.push_back(mk(1, 0, 64'hDEAD_BEEF_0000_0001, 1, 1, 2'd1, 1, 64'hDEAD_BEEF_0000_0001));
    vecs.push_back(mk(0, 1, 64'h0,                   0, 1, 2'd0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h1,                   1, 1, 2'd1, 1, 64'h1));
    vecs.push_back(mk(1, 0, 64'h2,                   1, 0, 2'd2, 1, 64'h1));
    vecs.push_back(mk(1, 0, 64'h3,                   1, 0, 2'd2, 1, 64'h1));
    vecs.push_back(mk(0, 1, 64'h0,                   1, 1, 2'd1, 1, 64'h2));
    vecs.push_back(mk(1, 1, 64'h4,                   1, 1, 2'd1, 1, 64'h4));
    vecs.push_back(mk(0, 0, 64'h0,                   1, 1, 2'd1, 1, 64'h4));
    vecs.push_back(mk(0, 1, 64'h0,                   0, 1, 2'd0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,                   0, 1, 2'd0, 0, 64'h0));
    vecs.push_back(mk(1, 0, 64'h5,                   1, 1, 2'd1, 1, 64'h5));
    vecs.push_back(mk(1, 1, 64'h6,                   1, 1, 2'd1, 1, 64'h6));
    vecs.push_back(mk(1, 0, 64'h7,                   1, 0, 2'd2, 1, 64'h6));
    vecs.push_back(mk(1, 1, 64'h8,                   1, 1, 2'd1, 1, 64'h7));
    vecs.push_back(mk(0, 1, 64'h0,                   0, 1, 2'd0, 0, 64'h0));

    drive(0, 0, 64'h0);
    #1;
    reset_n_i = 1'b0;
    drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) tick();
    chk("rst_v",     64'(bus.v_o),     64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_data",  bus.data_o,       64'd0);
    #2 reset_n_i = 1'b1;
    #1;
    chk("rel_v_pre",     64'(bus.v_o),     64'd0);
    chk("rel_ready_pre", 64'(bus.ready_o), 64'd0);
    tick();
    chk("rel_ready_post", 64'(bus.ready_o), 64'd1);
    chk("rel_count_post", 64'(bus.count_o), 64'd0);
    chk("rel_v_post",     64'(bus.v_o),     64'd0);
    drive(0, 0, 64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].y, vecs[i].d);
      tick();
      chk($sformatf("vec%0d_v", i),     64'(bus.v_o),     64'(vecs[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(bus.ready_o), 64'(vecs[i].er));
      chk($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(vecs[i].ec));
      if (vecs[i].cd)
        chk($sformatf("vec%0d_data", i), bus.data_o, vecs[i].ed);
    end

    // streaming: one transfer per cycle, occupancy pinned at 1
    drive(1, 0, 64'h1000);
    tick();
    chk("stream_first", bus.data_o, 64'h1000);
    for (int i = 1; i <= 100; i++) begin
      drive(1, 1, 64'h1000 + 64'(i));
      tick();
      chk("stream_v",     64'(bus.v_o),     64'd1);
      chk("stream_count", 64'(bus.count_o), 64'd1);
      chk("stream_data",  bus.data_o,       64'h1000 + 64'(i));
    end
    drive(0, 1, 64'h0);
    tick();
    chk("stream_drain", 64'(bus.count_o), 64'd0);

    // asynchronous reset while holding two entries
    drive(1, 0, 64'hA1);
    tick();
    drive(1, 0, 64'hA2);
    tick();
    drive(0, 0, 64'h0);
    chk("mid_two", 64'(bus.count_o), 64'd2);
    #2 reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v",     64'(bus.v_o),     64'd0);
    chk("mid_rst_count", 64'(bus.count_o), 64'd0);
    chk("mid_rst_data",  bus.data_o,       64'd0);
    chk("mid_rst_ready", 64'(bus.ready_o), 64'd0);
    #1 reset_n_i = 1'b1;
    tick();
    chk("mid_rel_ready", 64'(bus.ready_o), 64'd1);
    repeat (3) begin
      tick();
      chk("mid_no_ghost", 64'(bus.v_o), 64'd0);
    end
    drive(1, 0, 64'hB1);
    tick();
    chk("mid_new_data", bus.data_o, 64'hB1);
    drive(1, 0, 64'hB2);
    tick();
    drive(0, 1, 64'h0);
    tick();
    chk("mid_second", bus.data_o, 64'hB2);
    tick();
    drive(0, 0, 64'h0);
    chk("mid_empty", 64'(bus.count_o), 64'd0);

    // randomized traffic against a queue model
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic        y;
      logic        enq;
      logic [63:0] d;
      v = 1'($urandom_range(0, 1));
      y = (sb.size() > 0) && (1'($urandom_range(0, 1)) == 1'b1);
      d = {$urandom, $urandom};
      chk("rnd_count", 64'(bus.count_o), 64'(sb.size()));
      chk("rnd_ready", 64'(bus.ready_o), 64'(sb.size() != 2));
      chk("rnd_v",     64'(bus.v_o),     64'(sb.size() > 0));
      if (sb.size() > 0)
        chk("rnd_data", bus.data_o, sb[0]);
      enq = v && (sb.size() != 2);
      drive(v, y, d);
      tick();
      if (y)   void'(sb.pop_front());
      if (enq) sb.push_back(d);
    end
    drive(0, 0, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
